answer_judge: RTL and testbench
===============================

ANSWER_JUDGE -- requirements
Module: answer_judge

Interface
REQ-001 Parameter NUM_Q, default 10: number of questions per game; legal range 1..10; the question index runs 1..NUM_Q.
REQ-002 Parameter RESULT_HOLD, default 1000: number of cycles the verdict is held before advancing.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-005 START  input  1  one-cycle pulse that begins a game.
REQ-006 KEY_VALID  input  1  one-cycle strobe marking KEY_CODE as valid.
REQ-007 KEY_CODE  input  4  prime code entered by the player (1=2, 2=3, 3=5, 4=7, 5=11, 6=13, 7=17, 8=19, 9=23).
REQ-008 KEY_CLR  input  1  one-cycle pulse that discards the current entries.
REQ-009 QUESTION  input  24  word from the question table: [23:12] three BCD question digits; [11:8], [7:4], [3:0] answer prime codes. The table registers this word one cycle after it samples the index.
REQ-010 NUM_OUT  output  4  question index driven to the question table.
REQ-011 DISP_Q  output  12  latched BCD question digits, for display.
REQ-012 ENTERED  output  12  entered codes: slot0=[11:8], slot1=[7:4], slot2=[3:0].
REQ-013 ENTRY_CNT  output  2  number of codes entered, 0..3.
REQ-014 CORRECT  output  1  high during RESULT when the verdict is correct.
REQ-015 WRONG  output  1  high during RESULT when the verdict is wrong.
REQ-016 SCORE  output  4  number of correct answers in the current game; saturates at 15.
REQ-017 GAME_END  output  1  high while in DONE.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, INPUT, JUDGE, RESULT and DONE.
REQ-019 IDLE/DONE: on START, SHALL set NUM_OUT=1, SCORE=0, ENTERED=0, ENTRY_CNT=0, then enter FETCH; START in any other state is ignored.
REQ-020 FETCH SHALL last exactly 2 cycles with NUM_OUT stable, then latch QUESTION into an internal answer register and QUESTION[23:12] into DISP_Q, and enter INPUT.
REQ-021 INPUT: KEY_VALID with KEY_CODE in 1..9 and ENTRY_CNT<3 SHALL write KEY_CODE into slot ENTRY_CNT and increment ENTRY_CNT.
REQ-022 INPUT: KEY_VALID with KEY_CODE of 0 or 10..15 SHALL be ignored.
REQ-023 INPUT: KEY_CLR SHALL zero ENTERED and ENTRY_CNT; when KEY_CLR and KEY_VALID occur in the same cycle, KEY_CLR wins and the key is dropped.
REQ-024 The cycle after ENTRY_CNT becomes 3, the FSM SHALL enter JUDGE; keys in JUDGE, RESULT, FETCH, IDLE and DONE are ignored.
REQ-025 JUDGE SHALL last one cycle.
REQ-026 The verdict SHALL be correct iff ENTERED is a permutation of the three latched answer codes (order-insensitive multiset compare over all 6 orderings).
REQ-027 When correct, SCORE SHALL increment, saturating at 15.
REQ-028 On leaving JUDGE, exactly one of CORRECT/WRONG SHALL be asserted for the whole of RESULT.
REQ-029 RESULT SHALL last RESULT_HOLD cycles, then clear CORRECT, WRONG, ENTERED and ENTRY_CNT.
REQ-030 On leaving RESULT: if NUM_OUT==NUM_Q, the FSM SHALL enter DONE with NUM_OUT held; otherwise NUM_OUT SHALL increment and the FSM SHALL enter FETCH.
REQ-031 In DONE, GAME_END=1 and SCORE SHALL hold until the next START.
REQ-032 CORRECT, WRONG and GAME_END SHALL be registered outputs; outside RESULT, CORRECT and WRONG are 0.

Reset
REQ-033 When RST_N=0 at a rising edge, the FSM SHALL enter IDLE and NUM_OUT, DISP_Q, ENTERED, ENTRY_CNT, CORRECT, WRONG, SCORE, GAME_END and all counters SHALL be 0.
REQ-034 Reset SHALL override every other input in every state, including mid-FETCH, mid-INPUT and mid-RESULT; no partial entry or score is retained.

Verification
REQ-035 START, table word for index 1 = 0x027222, keys 2,2,2 -> JUDGE one cycle after third key; CORRECT=1 for RESULT_HOLD cycles; SCORE=1; NUM_OUT=2.
REQ-036 Index 2 word 0x042124, keys 4,1,2 -> CORRECT (order-insensitive); keys 1,1,2 -> WRONG, SCORE unchanged.
REQ-037 In INPUT: keys 3, 0, 12, then KEY_CLR together with KEY_VALID code 5 -> ENTRY_CNT=0, ENTERED=0; entries 0/12/5 have no effect.
REQ-038 NUM_Q=10, all answers correct -> NUM_OUT sweeps 1..10, each held 2 FETCH cycles before latch; after 10th RESULT: DONE, GAME_END=1, SCORE=10, NUM_OUT=10; a second START restarts with SCORE=0, NUM_OUT=1.
REQ-039 RST_N=0 for one cycle after 2 keys in INPUT -> next cycle IDLE with all outputs 0; START pulses during FETCH/INPUT/RESULT are ignored.

Source files
------------

// File: rtl/answer_judge.sv
// rtl/answer_judge.sv - prime-code answer judge: fetch question, collect three keys, judge, score
module answer_judge #(
    parameter int NUM_Q       = 10,
    parameter int RESULT_HOLD = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        KEY_VALID,
    input  logic [3:0]  KEY_CODE,
    input  logic        KEY_CLR,
    input  logic [23:0] QUESTION,
    output logic [3:0]  NUM_OUT,
    output logic [11:0] DISP_Q,
    output logic [11:0] ENTERED,
    output logic [1:0]  ENTRY_CNT,
    output logic        CORRECT,
    output logic        WRONG,
    output logic [3:0]  SCORE,
    output logic        GAME_END
);

    localparam int HW = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_INPUT, S_JUDGE, S_RESULT, S_DONE
    } state_t;

    state_t          r_state;
    logic            r_fetch_cnt;
    logic [HW-1:0]   r_hold_cnt;
    logic [11:0]     r_answer;
    logic [3:0]      r_num;
    logic [11:0]     r_disp;
    logic [11:0]     r_entered;
    logic [1:0]      r_cnt;
    logic            r_correct;
    logic            r_wrong;
    logic [3:0]      r_score;
    logic            r_game_end;

    logic [3:0]      w_a0, w_a1, w_a2, w_e0, w_e1, w_e2;
    logic            w_match;
    logic            w_key_ok;

    assign w_a0 = r_answer[11:8];
    assign w_a1 = r_answer[7:4];
    assign w_a2 = r_answer[3:0];
    assign w_e0 = r_entered[11:8];
    assign w_e1 = r_entered[7:4];
    assign w_e2 = r_entered[3:0];

    // Multiset equality: any of the six orderings of the answer matches the entry
    assign w_match = ((w_e0 == w_a0) && (w_e1 == w_a1) && (w_e2 == w_a2)) ||
                     ((w_e0 == w_a0) && (w_e1 == w_a2) && (w_e2 == w_a1)) ||
                     ((w_e0 == w_a1) && (w_e1 == w_a0) && (w_e2 == w_a2)) ||
                     ((w_e0 == w_a1) && (w_e1 == w_a2) && (w_e2 == w_a0)) ||
                     ((w_e0 == w_a2) && (w_e1 == w_a0) && (w_e2 == w_a1)) ||
                     ((w_e0 == w_a2) && (w_e1 == w_a1) && (w_e2 == w_a0));

    assign w_key_ok = KEY_VALID && (KEY_CODE != 4'd0) && (KEY_CODE <= 4'd9);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_fetch_cnt <= 1'b0;
            r_hold_cnt  <= '0;
            r_answer    <= '0;
            r_num       <= '0;
            r_disp      <= '0;
            r_entered   <= '0;
            r_cnt       <= '0;
            r_correct   <= 1'b0;
            r_wrong     <= 1'b0;
            r_score     <= '0;
            r_game_end  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_num       <= 4'd1;
                        r_score     <= '0;
                        r_entered   <= '0;
                        r_cnt       <= '0;
                        r_fetch_cnt <= 1'b0;
                        r_game_end  <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Table output lags the index by one cycle, so latch on the second cycle
                    if (r_fetch_cnt) begin
                        r_answer    <= QUESTION[11:0];
                        r_disp      <= QUESTION[23:12];
                        r_fetch_cnt <= 1'b0;
                        r_state     <= S_INPUT;
                    end else begin
                        r_fetch_cnt <= 1'b1;
                    end
                end
                S_INPUT: begin
                    if (r_cnt == 2'd3) begin
                        r_state <= S_JUDGE;
                    end else if (KEY_CLR) begin
                        r_entered <= '0;
                        r_cnt     <= '0;
                    end else if (w_key_ok) begin
                        case (r_cnt)
                            2'd0:    r_entered[11:8] <= KEY_CODE;
                            2'd1:    r_entered[7:4]  <= KEY_CODE;
                            default: r_entered[3:0]  <= KEY_CODE;
                        endcase
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_JUDGE: begin
                    r_correct  <= w_match;
                    r_wrong    <= !w_match;
                    if (w_match && (r_score != 4'd15))
                        r_score <= r_score + 4'd1;
                    r_hold_cnt <= '0;
                    r_state    <= S_RESULT;
                end
                S_RESULT: begin
                    if (r_hold_cnt == HW'(RESULT_HOLD - 1)) begin
                        r_correct <= 1'b0;
                        r_wrong   <= 1'b0;
                        r_entered <= '0;
                        r_cnt     <= '0;
                        if (r_num == 4'(NUM_Q)) begin
                            r_game_end <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_num       <= r_num + 4'd1;
                            r_fetch_cnt <= 1'b0;
                            r_state     <= S_FETCH;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign NUM_OUT   = r_num;
    assign DISP_Q    = r_disp;
    assign ENTERED   = r_entered;
    assign ENTRY_CNT = r_cnt;
    assign CORRECT   = r_correct;
    assign WRONG     = r_wrong;
    assign SCORE     = r_score;
    assign GAME_END  = r_game_end;

endmodule

// File: tb/tb_answer_judge.sv
// tb/tb_answer_judge.sv - directed self-checking bench for answer_judge
module tb_answer_judge;

    localparam int NQ   = 10;
    localparam int HOLD = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic        KEY_VALID;
    logic [3:0]  KEY_CODE;
    logic        KEY_CLR;
    logic [23:0] QUESTION;
    logic [3:0]  NUM_OUT;
    logic [11:0] DISP_Q;
    logic [11:0] ENTERED;
    logic [1:0]  ENTRY_CNT;
    logic        CORRECT;
    logic        WRONG;
    logic [3:0]  SCORE;
    logic        GAME_END;

    int checks = 0;
    int errors = 0;

    logic [23:0] qtab [1:10];

    answer_judge #(.NUM_Q(NQ), .RESULT_HOLD(HOLD)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .KEY_VALID(KEY_VALID),
        .KEY_CODE(KEY_CODE), .KEY_CLR(KEY_CLR), .QUESTION(QUESTION),
        .NUM_OUT(NUM_OUT), .DISP_Q(DISP_Q), .ENTERED(ENTERED),
        .ENTRY_CNT(ENTRY_CNT), .CORRECT(CORRECT), .WRONG(WRONG),
        .SCORE(SCORE), .GAME_END(GAME_END)
    );

    always #5 CLK = ~CLK;

    // Question table: registers the word one cycle after sampling the index
    always @(posedge CLK) begin
        if (NUM_OUT >= 4'd1 && NUM_OUT <= 4'd10)
            QUESTION <= qtab[NUM_OUT];
        else
            QUESTION <= 24'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic key(input logic [3:0] code);
        KEY_VALID = 1'b1;
        KEY_CODE  = code;
        tick();
        KEY_VALID = 1'b0;
        KEY_CODE  = 4'd0;
    endtask

    // Entered right after the edge that moved the DUT into FETCH
    task automatic do_fetch(input int idx, input bit start_pulse);
        chk("fetch_num_c1", NUM_OUT, idx);
        START = start_pulse;
        tick();
        START = 1'b0;
        chk("fetch_num_c2", NUM_OUT, idx);
        chk("fetch_cnt_c2", ENTRY_CNT, 0);
        tick();
        chk("fetch_disp", DISP_Q, qtab[idx][23:12]);
        chk("fetch_num_latched", NUM_OUT, idx);
    endtask

    task automatic play(input int idx, input logic [3:0] k0, input logic [3:0] k1,
                        input logic [3:0] k2, input bit exp_ok, input int exp_score,
                        input bit start_in_result);
        key(k0);
        key(k1);
        key(k2);
        chk("entry_cnt3", ENTRY_CNT, 3);
        chk("entered", ENTERED, {k0, k1, k2});
        tick();
        chk("judge_no_verdict", {CORRECT, WRONG}, 2'b00);
        tick();
        chk("verdict", {CORRECT, WRONG}, exp_ok ? 2'b10 : 2'b01);
        chk("score", SCORE, exp_score);
        START = start_in_result;
        for (int i = 0; i < HOLD - 1; i++) tick();
        START = 1'b0;
        chk("verdict_held", {CORRECT, WRONG}, exp_ok ? 2'b10 : 2'b01);
        tick();
        chk("verdict_clear", {CORRECT, WRONG}, 2'b00);
        chk("entry_clear", {ENTERED, 2'b00, ENTRY_CNT}, 0);
        chk("next_num", NUM_OUT, (idx == NQ) ? idx : idx + 1);
        chk("game_end", GAME_END, (idx == NQ) ? 1 : 0);
    endtask

    initial begin
        logic [23:0] w;
        qtab[1]  = 24'h027222;
        qtab[2]  = 24'h042124;
        qtab[3]  = 24'h105357;
        qtab[4]  = 24'h221999;
        qtab[5]  = 24'h187189;
        qtab[6]  = 24'h300456;
        qtab[7]  = 24'h512678;
        qtab[8]  = 24'h733123;
        qtab[9]  = 24'h899555;
        qtab[10] = 24'h960147;

        RST_N = 1'b0; START = 1'b1; KEY_VALID = 1'b0; KEY_CODE = 4'd0; KEY_CLR = 1'b0;
        tick();
        tick();
        chk("rst_num", NUM_OUT, 0);
        chk("rst_disp", DISP_Q, 0);
        chk("rst_entered", ENTERED, 0);
        chk("rst_score", SCORE, 0);
        chk("rst_flags", {CORRECT, WRONG, GAME_END, ENTRY_CNT}, 0);
        START = 1'b0;
        RST_N = 1'b1;
        key(4'd3);
        chk("idle_key_ignored", ENTRY_CNT, 0);

        // Game 1: every answer correct, entered in rotated order
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int idx = 1; idx <= NQ; idx++) begin
            do_fetch(idx, 1'b0);
            w = qtab[idx];
            if (idx == 3) begin
                key(4'd3);
                chk("junk_k3_cnt", ENTRY_CNT, 1);
                key(4'd0);
                key(4'd12);
                chk("junk_ignored_cnt", ENTRY_CNT, 1);
                chk("junk_ignored_ent", ENTERED, 12'h300);
                KEY_CLR = 1'b1;
                key(4'd5);
                KEY_CLR = 1'b0;
                chk("clr_wins_cnt", ENTRY_CNT, 0);
                chk("clr_wins_ent", ENTERED, 0);
            end
            play(idx, w[3:0], w[11:8], w[7:4], 1'b1, idx, 1'b0);
        end
        key(4'd2);
        tick();
        chk("done_score", SCORE, 10);
        chk("done_game_end", GAME_END, 1);
        chk("done_num", NUM_OUT, 10);
        chk("done_key_ignored", ENTRY_CNT, 0);

        // Game 2: restart, one correct, one wrong, ignored STARTs, then reset mid-entry
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("restart_score", SCORE, 0);
        chk("restart_game_end", GAME_END, 0);
        do_fetch(1, 1'b0);
        play(1, 4'd2, 4'd2, 4'd2, 1'b1, 1, 1'b0);
        do_fetch(2, 1'b0);
        play(2, 4'd1, 4'd1, 4'd2, 1'b0, 1, 1'b1);
        do_fetch(3, 1'b1);
        key(4'd3);
        key(4'd5);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("start_in_input_cnt", ENTRY_CNT, 2);
        chk("start_in_input_num", NUM_OUT, 3);
        chk("start_in_input_ent", ENTERED, 12'h350);
        RST_N = 1'b0;
        KEY_VALID = 1'b1; KEY_CODE = 4'd7;
        tick();
        RST_N = 1'b1;
        KEY_VALID = 1'b0; KEY_CODE = 4'd0;
        chk("midrst_num", NUM_OUT, 0);
        chk("midrst_disp", DISP_Q, 0);
        chk("midrst_entered", ENTERED, 0);
        chk("midrst_score", SCORE, 0);
        chk("midrst_flags", {CORRECT, WRONG, GAME_END, ENTRY_CNT}, 0);
        key(4'd7);
        chk("midrst_idle", ENTRY_CNT, 0);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("after_rst_start", NUM_OUT, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
